rom_seq_reader: RTL and testbench
=================================

# rom_seq_reader

Read-side controller for the team's 8x8 chip-selected ROMs. On a `start` request it walks a contiguous, wrapping address window of the ROM, drives `cs`, `read_en` and the address, and registers each returned byte. It streams the bytes downstream over a valid/ready handshake and accumulates a modulo-256 checksum. It sits between a ROM instance and any consumer that needs table contents as a byte stream.

## Interface
Parameters:
- `ADDR_W`, default 3: ROM address width; depth is 2**ADDR_W.
- `DATA_W`, default 8: ROM data width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request to begin a read burst; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first address of the burst; sampled with `start`.
- `count`  in  ADDR_W+1  number of bytes to read; 0 means full depth (8); sampled with `start`.
- `rom_cs`  out  1  ROM chip select.
- `rom_read_en`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM address.
- `rom_data`  in  DATA_W  ROM data. It is combinational and tri-stated when not enabled.
- `out_data`  out  DATA_W  current output byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `busy`  out  1  a burst is in progress.
- `done`  out  1  one-cycle pulse when the burst completes.
- `checksum`  out  DATA_W  running modulo-256 sum of bytes read in the current or last burst.

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - `start`=1 latches `cur_addr`←`base_addr` and `remaining`←(`count`==0 ? 8 : `count`).
  - It clears `checksum` and moves to READ.
- READ:
  - `rom_cs`=`rom_read_en`=1 and `rom_addr`=`cur_addr` for exactly one cycle.
  - At the closing edge: `out_data`←`rom_data`, `checksum`←`checksum`+`rom_data` (mod 256), then go to SEND.
- SEND:
  - `out_valid`=1 and `out_data` is held stable.
  - On `out_valid`&&`out_ready`: if `remaining`==1, go to DONE.
  - Otherwise `cur_addr`←`cur_addr`+1 (wraps 7→0), `remaining`←`remaining`−1, and go to READ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in READ, SEND and DONE.
- `rom_cs` and `rom_read_en` are 0 in every state except READ. `rom_data` is never sampled outside READ.
- `start` while not in IDLE is ignored, with no queuing.
- After DONE, `checksum` and `out_data` hold their last values until the next accepted `start`.
- Address arithmetic is ADDR_W bits, naturally wrapping. `remaining` is ADDR_W+1 bits.

## Timing
- Reset values:
  - state=IDLE, `rom_cs`=0, `rom_read_en`=0, `rom_addr`=0.
  - `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `checksum`=0.
  - Internal `cur_addr`=0 and `remaining`=0.
- Latency: `start` at edge N puts READ in cycle N+1. The first `out_valid` is in cycle N+2.
- Throughput: with `out_ready` held at 1, one byte every 2 cycles.
- Handshake:
  - `out_valid` and `out_data` must not change until accepted.
  - `out_ready` is a don't-care when `out_valid`=0.
  - Backpressure of any length is allowed.
- `done` asserts in the cycle after the last handshake. A burst of k bytes with no stall takes 2k+1 cycles from the first READ to the end of DONE.
- `rst_n` low mid-burst:
  - Immediately forces reset values, so `rom_cs` and `rom_read_en` drop asynchronously.
  - The partial burst is abandoned and there is no `done`.

## Structure
- Package `rom_seq_pkg`:
  - FSM state enum.
  - `ROM_DEPTH` = 2**ADDR_W.
  - Checksum width constant.
- No RTL sub-module; the design is a single FSM plus datapath.
- The bench instantiates the existing 8x8 ROM (contents 2e,38,4c,58,68,7f,88,9a) as the responder on `rom_*`.

## Test plan
- Full sweep: `base_addr`=0, `count`=0, `out_ready`=1.
  - Required: bytes 2e,38,4c,58,68,7f,88,9a in order, one every 2 cycles, `checksum`=0x13, and one `done` pulse.
- Wrap: `base_addr`=6, `count`=4.
  - Required: 88,9a,2e,38, with `rom_addr` sequence 6,7,0,1, and `checksum`=0x88.
- Single byte with backpressure: `base_addr`=3, `count`=1, `out_ready` low for 5 cycles.
  - Required: `out_valid` is held with `out_data`=0x58 stable and `rom_cs` stays 0 during the stall.
  - Then `done` follows acceptance and `checksum`=0x58.
- `start` pulsed during SEND of a 4-byte burst.
  - Required: it is ignored; exactly 4 bytes and one `done`.
- `rst_n` asserted while in READ of the third byte.
  - Required: all outputs return to reset values immediately.
  - A new `start` (`base_addr`=0, `count`=2) then yields 2e,38 and `checksum`=0x66.
- Idle check: no `start`.
  - Required: `rom_cs`=`rom_read_en`=0 and `out_valid`=0 for 20 cycles.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the chip-selected ROM sequential reader.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

  localparam int unsigned ROM_ADDR_W = 3;
  localparam int unsigned ROM_DEPTH  = 2 ** ROM_ADDR_W;
  localparam int unsigned CHECKSUM_W = 8;

endpackage

// File: rtl/rom_seq_reader_if.sv
// ROM access bus plus downstream byte stream, grouped for rom_seq_reader.
interface rom_seq_reader_if #(
  parameter int unsigned ADDR_W = rom_seq_pkg::ROM_ADDR_W,
  parameter int unsigned DATA_W = rom_seq_pkg::CHECKSUM_W
);

  logic              rom_cs;
  logic              rom_read_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Reader side: drives the ROM and produces the stream.
  modport master (
    output rom_cs, rom_read_en, rom_addr,
    input  rom_data,
    output out_data, out_valid,
    input  out_ready
  );

  // ROM plus consumer side.
  modport slave (
    input  rom_cs, rom_read_en, rom_addr,
    output rom_data,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/rom_seq_reader.sv
// Walks a wrapping ROM address window, streams each byte over valid/ready and
// accumulates a modulo-2**DATA_W checksum of the bytes read.
module rom_seq_reader
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = CHECKSUM_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W:0]      count_i,
  rom_seq_reader_if.master     bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATA_W-1:0]    checksum_o
);

  // A count of zero requests the whole ROM.
  localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                rom_en;
  logic                out_valid;
  logic                done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;
    rom_en      = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cur_addr_d  = base_addr_i;
          remaining_d = (count_i == '0) ? FullCount : count_i;
          checksum_d  = '0;
          state_d     = StRead;
        end
      end
      StRead: begin
        // rom_data is only valid while the ROM is enabled, i.e. this state.
        rom_en     = 1'b1;
        out_data_d = bus.rom_data;
        checksum_d = checksum_q + bus.rom_data;
        state_d    = StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (remaining_q == (ADDR_W + 1)'(1)) begin
            state_d = StDone;
          end else begin
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - (ADDR_W + 1)'(1);
            state_d     = StRead;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rom_cs      = rom_en;
  assign bus.rom_read_en = rom_en;
  assign bus.rom_addr    = cur_addr_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done;
  assign checksum_o      = checksum_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// Randomized and directed bench for rom_seq_reader against a queue-based burst model.
module tb_rom_seq_reader;
  import rom_seq_pkg::*;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] rom_mem [ROM_DEPTH];

  rom_seq_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  // 8x8 ROM responder: combinational, floating when not enabled.
  assign bus.rom_data = (bus.rom_cs && bus.rom_read_en) ? rom_mem[bus.rom_addr] : 'z;

  rom_seq_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .count_i     (count),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .checksum_o  (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cs"},       32'(bus.rom_cs), 32'(0));
    check({tag, "_re"},       32'(bus.rom_read_en), 32'(0));
    check({tag, "_addr"},     32'(bus.rom_addr), 32'(0));
    check({tag, "_data"},     32'(bus.out_data), 32'(0));
    check({tag, "_valid"},    32'(bus.out_valid), 32'(0));
    check({tag, "_busy"},     32'(busy), 32'(0));
    check({tag, "_done"},     32'(done), 32'(0));
    check({tag, "_checksum"}, 32'(checksum), 32'(0));
  endtask

  // ready_mode: 0 always ready, 1 random, 2 low for the first 5 valid cycles.
  // abort_read: stop (without final checks) once that many ROM reads were seen.
  task automatic run_burst(input int unsigned b, input int unsigned c, input int ready_mode,
                           input bit poke_start, input int unsigned abort_read);
    logic [DW-1:0] exp_bytes [$];
    int unsigned   exp_addrs [$];
    int unsigned   n, sum, cyc, reads, stalls, done_cnt;
    bit            finished, prev_valid, last_ready, poked, r;
    logic [DW-1:0] prev_data;

    n = (c == 0) ? ROM_DEPTH : c;
    sum = 0;
    for (int i = 0; i < int'(n); i++) begin
      exp_addrs.push_back((b + i) % ROM_DEPTH);
      exp_bytes.push_back(rom_mem[(b + i) % ROM_DEPTH]);
      sum = (sum + rom_mem[(b + i) % ROM_DEPTH]) % 256;
    end

    start = 1'b1;
    base_addr = AW'(b);
    count = (AW + 1)'(c);
    @(posedge clk); #1;
    start = 1'b0;

    cyc = 0; reads = 0; stalls = 0; done_cnt = 0;
    finished = 0; prev_valid = 0; last_ready = 0; poked = 0; prev_data = '0;
    while (cyc < 400 && !finished) begin
      cyc++;
      check("busy", 32'(busy), 32'(1));
      if (prev_valid && !last_ready) begin
        check("hold_valid", 32'(bus.out_valid), 32'(1));
        check("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.rom_cs) begin
        reads++;
        check("rom_read_en", 32'(bus.rom_read_en), 32'(1));
        if (exp_addrs.size() == 0) check("extra_read", 32'(1), 32'(0));
        else check("rom_addr", 32'(bus.rom_addr), exp_addrs.pop_front());
        if (abort_read != 0 && reads == abort_read) return;
      end
      if (bus.out_valid) check("cs_idle_in_send", 32'(bus.rom_cs), 32'(0));

      start = 1'b0;
      if (poke_start && bus.out_valid && !poked) begin
        start = 1'b1;
        base_addr = AW'($urandom_range(0, 7));
        count = (AW + 1)'($urandom_range(0, 8));
        poked = 1;
      end

      case (ready_mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = (stalls >= 5);
          if (bus.out_valid && !r) stalls++;
        end
      endcase
      bus.out_ready = r;

      if (bus.out_valid && r) begin
        if (exp_bytes.size() == 0) check("extra_byte", 32'(1), 32'(0));
        else check("out_data", 32'(bus.out_data), 32'(exp_bytes.pop_front()));
      end
      if (done) begin
        done_cnt++;
        finished = 1;
        if (ready_mode == 0) check("burst_cycles", cyc, 2 * n + 1);
      end
      prev_valid = bus.out_valid;
      prev_data = bus.out_data;
      last_ready = r;
      @(posedge clk); #1;
    end
    start = 1'b0;

    check("done_seen", 32'(done_cnt), 32'(1));
    check("bytes_left", exp_bytes.size(), 32'(0));
    check("reads_left", exp_addrs.size(), 32'(0));
    check("checksum", 32'(checksum), sum);
    check("done_pulse_end", 32'(done), 32'(0));
    check("idle_after_done", 32'(busy), 32'(0));
    check("data_held", 32'(bus.out_data), 32'(prev_data));
  endtask

  initial begin
    rom_mem = '{8'h2e, 8'h38, 8'h4c, 8'h58, 8'h68, 8'h7f, 8'h88, 8'h9a};
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle: nothing should move without start.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_quiet", 32'({bus.rom_cs, bus.rom_read_en, bus.out_valid}), 32'(0));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;

    run_burst(0, 0, 0, 0, 0);
    check("sweep_checksum", 32'(checksum), 32'h13);
    run_burst(6, 4, 0, 0, 0);
    check("wrap_checksum", 32'(checksum), 32'h88);
    run_burst(3, 1, 2, 0, 0);
    check("single_checksum", 32'(checksum), 32'h58);
    run_burst(1, 4, 0, 1, 0);

    // Reset while the third byte is being read.
    run_burst(0, 4, 0, 0, 3);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk); #1;
    check("midreset_no_done", 32'(done), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_idle", 32'({busy, done}), 32'(0));
    run_burst(0, 2, 0, 0, 0);
    check("restart_checksum", 32'(checksum), 32'h66);

    for (int t = 0; t < 16; t++) begin
      run_burst($urandom_range(0, 7), $urandom_range(0, 8), 1, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
